// File: rtl/reg_file_sb_pkg.sv
// Shared register-file types and ABI register indices for the decode and writeback stages.
package rf_pkg;
  localparam int RF_ADDRESS_WIDTH = 5;
  localparam int RF_DATA_WIDTH    = 32;

  typedef logic [RF_ADDRESS_WIDTH-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd2;
  localparam reg_idx_t REG_A0   = 5'd10;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus into the register file: read ports, writeback, issue and status.
interface reg_file_sb_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2
);
  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0]    rd_data;
  logic [NUM_READ-1:0]               rd_busy;
  logic                              we;
  logic [ADDRESS_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]             wr_data;
  logic                              iss_en;
  logic [ADDRESS_WIDTH-1:0]          iss_rd;
  logic [DATA_WIDTH-1:0]             a0;
  logic                              sb_err;

  modport master (
    output rd_addr, we, wr_addr, wr_data, iss_en, iss_rd,
    input  rd_data, rd_busy, a0, sb_err
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data, iss_en, iss_rd,
    output rd_data, rd_busy, a0, sb_err
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending bits for hazard stalls, with a sticky double-issue error flag.
module reg_scoreboard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              iss_en,
  input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
  input  logic                              we,
  input  logic [ADDRESS_WIDTH-1:0]          wr_addr,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [NUM_READ-1:0]               byp_hit,
  output logic [NUM_READ-1:0]               rd_busy,
  output logic                              sb_err
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = {ADDRESS_WIDTH{1'b0}};

  logic [DEPTH-1:0] pending_r;
  logic [DEPTH-1:0] pending_nxt_s;
  logic             err_set_s;
  logic             sb_err_r;

  // Next pending vector: clear on writeback, then set on issue so a new producer wins.
  always_comb begin
    pending_nxt_s = pending_r;
    err_set_s     = 1'b0;
    if (we) begin
      pending_nxt_s[wr_addr] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (iss_en && (iss_rd != ZERO_IDX)) begin
      pending_nxt_s[iss_rd] = 1'b1;
      err_set_s = pending_r[iss_rd] && !(we && (wr_addr == iss_rd));
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Pending state and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {DEPTH{1'b0}};
      sb_err_r  <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      sb_err_r  <= sb_err_r | err_set_s;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
    assign rd_busy[i] = pending_r[rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]] & ~byp_hit[i];
  end

  assign sb_err = sb_err_r;
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with hardwired x0, optional write bypass, a0 tap and hazard scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int NUM_READ      = 2,
  parameter int BYPASS        = 1,
  parameter int TAP_REG       = int'(REG_A0)
) (
  input logic           clk,
  input logic           rst_n,
  reg_file_sb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] TAP_IDX  = TAP_REG[ADDRESS_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] regs_r [DEPTH];
  logic                  wr_ok_s;
  logic [NUM_READ-1:0]   byp_hit_s;

  assign wr_ok_s = bus.we && (bus.wr_addr != ZERO_IDX);

  // Storage: x0 is never written, so it stays zero from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_r[r] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] addr_s;
    assign addr_s       = bus.rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign byp_hit_s[i] = (BYPASS != 0) && wr_ok_s && (bus.wr_addr == addr_s);
    assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
        (addr_s == ZERO_IDX) ? {DATA_WIDTH{1'b0}} :
        byp_hit_s[i]         ? bus.wr_data        : regs_r[addr_s];
  end

  // The tap shows committed state only; debug must not see in-flight writeback data.
  assign bus.a0 = regs_r[TAP_IDX];

  reg_scoreboard #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_READ     (NUM_READ)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .iss_en (bus.iss_en),
    .iss_rd (bus.iss_rd),
    .we     (bus.we),
    .wr_addr(bus.wr_addr),
    .rd_addr(bus.rd_addr),
    .byp_hit(byp_hit_s),
    .rd_busy(bus.rd_busy),
    .sb_err (bus.sb_err)
  );
endmodule
